// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package wb_pkg;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 16;

    localparam logic [ADDR_W-1:0] REG_ZERO = 4'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Width of a pointer that indexes n requesters (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: per-requester valid/addr/data with a one-hot ready.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 16
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    // Requester side.
    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    // Arbiter side.
    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the pointer lands on
// bit 0, pick the lowest set bit, then rotate the grant back.
module rr_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [N-1:0] req_rot;
    logic [N-1:0] gnt_rot;
    logic         found;

    // Rotate-priority-rotate back; no grant at all when disabled.
    always_comb begin
        req_rot = N'({req, req} >> ptr);
        gnt_rot = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (en && req_rot[i] && !found) begin
                gnt_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
        grant = N'(({gnt_rot, gnt_rot} << ptr) >> N);
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources with a
// registered output stage, and tracks per-register busy bits for decode.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_arbiter_if.slave req_bus,
    input  logic                wb_stall,
    input  logic                claim_valid,
    input  logic [ADDR_W-1:0]   claim_addr,
    output logic                rf_regWrite,
    output logic [ADDR_W-1:0]   rf_write_reg,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [1:0]          grant_id
);

    import wb_pkg::*;

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);

    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          gid_q, gid_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic [NUM_REQ-1:0]  grant;
    logic                xfer;
    logic [PTR_W-1:0]    sel_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_bus.req_valid),
        .en    (!wb_stall && !reset),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign req_bus.req_ready = grant;

    // Mux the granted requester's index, address and data.
    always_comb begin
        xfer     = |grant;
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx  = PTR_W'(i);
                sel_addr = req_bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state for pointer, output stage and busy scoreboard.
    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        gid_d  = gid_q;
        if (xfer) begin
            ptr_d  = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
            we_d   = (sel_addr != ADDR_W'(REG_ZERO));
            addr_d = sel_addr;
            data_d = sel_data;
            gid_d  = 2'(sel_idx);
        end
        // Clear lands with the write; a claim at the same edge overrides it.
        busy_d = busy_q;
        if (we_q) begin
            busy_d[addr_q] = 1'b0;
        end
        if (claim_valid && (claim_addr != ADDR_W'(REG_ZERO))) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
            busy_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gid_q  <= gid_d;
            busy_q <= busy_d;
        end
    end

    assign rf_regWrite   = we_q;
    assign rf_write_reg  = addr_q;
    assign rf_write_data = data_q;
    assign busy_vec      = busy_q;
    assign grant_id      = gid_q;

endmodule
